// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes and FSM states.
package dmem_responder_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for dmem_responder: byte enables and shifted store data,
// right-justified load data, and an alignment/size error flag (illegal size also flags).
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_rd_shifted;

    // Lane shift of both data paths, then size-dependent enables, masking and alignment check.
    always_comb begin
        w_rd_shifted = i_rdata_word >> {i_lane, 3'b000};
        o_wdata      = i_wdata << {i_lane, 3'b000};
        o_be         = 4'b0000;
        o_rdata      = 32'd0;
        o_misalign   = 1'b1;
        case (i_size)
            MEM_B: begin
                o_be       = 4'b0001 << i_lane;
                o_rdata    = {24'd0, w_rd_shifted[7:0]};
                o_misalign = 1'b0;
            end
            MEM_H: begin
                o_be       = 4'b0011 << i_lane;
                o_rdata    = {16'd0, w_rd_shifted[15:0]};
                o_misalign = i_lane[0];
            end
            MEM_W: begin
                o_be       = 4'b1111;
                o_rdata    = w_rd_shifted;
                o_misalign = (i_lane != 2'd0);
            end
            default: begin
                o_be       = 4'b0000;
                o_rdata    = 32'd0;
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a byte/half/word
// access on an internal word array. Optional host register enabled by DMEM_TOHOST_EN.
//
// state    | meaning
// S_IDLE   | ready for a request; latches it on handshake
// S_WAIT   | wait-state down-counter running, ACCESS when it reaches 0
// S_ACCESS | decode, array read/write, response registered
// S_RESP   | rsp_valid strobe for one cycle
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
`ifdef DMEM_TOHOST_EN
    ,
    parameter logic [31:0] TOHOST_ADDR = 32'h0011_0000
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
`ifdef DMEM_TOHOST_EN
    ,
    output logic [31:0] o_tohost
`endif
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;
    logic [1:0]  w_lane;
    logic        w_range_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_rdata;
    logic        w_misalign;
    logic        w_err;
    logic        w_mem_store;

    assign w_accept    = (r_state == S_IDLE) && i_req_valid;
    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

    // Unsigned offset: addresses below BASE_ADDR wrap to large values and fall out of range.
    assign w_off       = r_addr - BASE_ADDR;
    assign w_idx       = w_off[AW+1:2];
    assign w_lane      = w_off[1:0];
    assign w_range_err = (w_off >= SPAN);

    dmem_lane_align u_lane_align (
        .i_size       (r_size),
        .i_lane       (w_lane),
        .i_wdata      (r_wdata),
        .i_rdata_word (r_mem[w_idx]),
        .o_be         (w_be),
        .o_wdata      (w_wdata_sh),
        .o_rdata      (w_rdata),
        .o_misalign   (w_misalign)
    );

`ifdef DMEM_TOHOST_EN
    logic        w_tohost_hit;
    logic        w_tohost_wr;
    logic [31:0] r_tohost;

    assign w_tohost_hit = (r_addr == TOHOST_ADDR);
    assign w_tohost_wr  = w_tohost_hit && r_write && (r_size == MEM_W);
    assign w_err        = w_tohost_hit ? !w_tohost_wr : (w_range_err || w_misalign);
    assign w_mem_store  = r_write && !w_err && !w_tohost_wr;
    assign o_tohost     = r_tohost;

    // Host register captures word stores to TOHOST_ADDR.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tohost <= 32'd0;
        end else if ((r_state == S_ACCESS) && w_tohost_wr) begin
            r_tohost <= r_wdata;
        end
    end
`else
    assign w_err       = w_range_err || w_misalign;
    assign w_mem_store = r_write && !w_err;
`endif

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = NO_WAIT ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State register, wait counter, request latch and registered response.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write <= i_req_write;
                r_size  <= i_req_size;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_ACCESS) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || r_write) ? 32'd0 : w_rdata;
            end
        end
    end

    // Array write; contents survive reset, but reset blocks a store still in flight.
    always_ff @(posedge i_clk) begin
        if (!i_reset && (r_state == S_ACCESS) && w_mem_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WAIT_CYCLES=1 instance for functional/boundary cases,
// WAIT_CYCLES=0 instance for back-to-back acceptance spacing.
module tb_dmem_responder;

    localparam logic [31:0] BASE   = 32'h0010_0000;
    localparam logic [31:0] TOHOST = 32'h0011_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        a_req_valid = 1'b0, a_req_write = 1'b0;
    logic [1:0]  a_req_size = 2'b00;
    logic [31:0] a_req_addr = 32'd0, a_req_wdata = 32'd0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [1:0]  b_req_size = 2'b00;
    logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
`ifdef DMEM_TOHOST_EN
    logic [31:0] a_tohost, b_tohost;
`endif

    exp_t qa[$];
    exp_t qb[$];
    int   last_acc[2];

    dmem_responder #(.WAIT_CYCLES(1)) u_dut_a (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_write(a_req_write),
        .i_req_size(a_req_size), .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
        .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err)
`ifdef DMEM_TOHOST_EN
        , .o_tohost(a_tohost)
`endif
    );

    dmem_responder #(.WAIT_CYCLES(0)) u_dut_b (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_write(b_req_write),
        .i_req_size(b_req_size), .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
        .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err)
`ifdef DMEM_TOHOST_EN
        , .o_tohost(b_tohost)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            a_req_valid = v; a_req_write = wr; a_req_size = sz; a_req_addr = addr; a_req_wdata = wd;
        end else begin
            b_req_valid = v; b_req_write = wr; b_req_size = sz; b_req_addr = addr; b_req_wdata = wd;
        end
    endtask

    task automatic issue(input int sel, input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err,
                         input bit expect_rsp);
        int n;
        exp_t e;
        @(negedge clk);
        drive(sel, 1'b1, wr, sz, addr, wd);
        n = 0;
        while (!((sel == 0) ? a_req_ready : b_req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!((sel == 0) ? a_req_ready : b_req_ready)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: dut %0d req_ready stayed 0 for %0d cycles, required 1", sel, n);
            drive(sel, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
            return;
        end
        last_acc[sel] = cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.acc   = cyc;
        if (expect_rsp) begin
            if (sel == 0) qa.push_back(e);
            else qb.push_back(e);
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    int unexpected = 0;

    // Response monitor, DUT A (expected latency 3 from accept cycle).
    always @(negedge clk) begin
        if (a_rsp_valid) begin
            if (qa.size() == 0) begin
                unexpected++;
                $display("FAIL a_unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_rdata", a_rsp_rdata, e.rdata);
                check("a_err", 32'(a_rsp_err), 32'(e.err));
                check("a_latency", 32'(cyc - e.acc), 32'd3);
            end
        end
    end

    // Response monitor, DUT B (expected latency 2 from accept cycle).
    always @(negedge clk) begin
        if (b_rsp_valid) begin
            if (qb.size() == 0) begin
                unexpected++;
                $display("FAIL b_unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_rdata", b_rsp_rdata, e.rdata);
                check("b_err", 32'(b_rsp_err), 32'(e.err));
                check("b_latency", 32'(cyc - e.acc), 32'd2);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int acc_b[3];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(a_req_ready), 32'd1);
        check("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(a_rsp_err), 32'd0);
        check("reset_rsp_rdata", a_rsp_rdata, 32'd0);

        //     sel wr  size   addr             wdata         exp_rdata     err  rsp
        issue(0, 1, 2'b10, BASE + 32'h8,    32'hDEADBEEF, 32'h0,        0,   1);
        issue(0, 0, 2'b10, BASE + 32'h8,    32'h0,        32'hDEADBEEF, 0,   1);
        issue(0, 1, 2'b00, BASE + 32'h9,    32'h000000AA, 32'h0,        0,   1);
        issue(0, 0, 2'b10, BASE + 32'h8,    32'h0,        32'hDEADAAEF, 0,   1);
        issue(0, 0, 2'b00, BASE + 32'hB,    32'h0,        32'h000000DE, 0,   1);
        issue(0, 0, 2'b01, BASE + 32'hA,    32'h0,        32'h0000DEAD, 0,   1);
        issue(0, 0, 2'b00, BASE + 32'h9,    32'h0,        32'h000000AA, 0,   1);
        issue(0, 0, 2'b01, BASE + 32'h3,    32'h0,        32'h0,        1,   1);
        issue(0, 1, 2'b10, BASE + 32'h2,    32'h11111111, 32'h0,        1,   1);
        issue(0, 0, 2'b10, BASE + 32'h8,    32'h0,        32'hDEADAAEF, 0,   1);
        issue(0, 0, 2'b11, BASE + 32'h8,    32'h0,        32'h0,        1,   1);
        issue(0, 0, 2'b10, BASE + 32'h1000, 32'h0,        32'h0,        1,   1);
        issue(0, 0, 2'b10, BASE - 32'h4,    32'h0,        32'h0,        1,   1);
        issue(0, 1, 2'b10, BASE + 32'hC,    32'h0,        32'h0,        0,   1);
        issue(0, 1, 2'b01, BASE + 32'hE,    32'hFFFF5678, 32'h0,        0,   1);
        issue(0, 1, 2'b00, BASE + 32'hC,    32'h000001FF, 32'h0,        0,   1);
        issue(0, 0, 2'b10, BASE + 32'hC,    32'h0,        32'h567800FF, 0,   1);
        issue(0, 0, 2'b01, BASE + 32'hE,    32'h0,        32'h00005678, 0,   1);
        issue(0, 0, 2'b10, TOHOST,          32'h0,        32'h0,        1,   1);
        issue(0, 1, 2'b10, BASE,            32'hCAFEF00D, 32'h0,        0,   1);

        // Store aborted by reset while in WAIT: no response, word keeps its old value.
        issue(0, 1, 2'b10, BASE,            32'h00001234, 32'h0,        0,   0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 32'(a_req_ready), 32'd1);
        check("abort_rsp_valid", 32'(a_rsp_valid), 32'd0);
        issue(0, 0, 2'b10, BASE,            32'h0,        32'hCAFEF00D, 0,   1);

`ifdef DMEM_TOHOST_EN
        issue(0, 1, 2'b10, TOHOST,          32'h00000001, 32'h0,        0,   1);
        drain();
        check("tohost", a_tohost, 32'h00000001);
`endif

        // Zero-wait instance: back-to-back requests accepted every 3 cycles.
        issue(1, 1, 2'b10, BASE + 32'h10,   32'h00000055, 32'h0,        0,   1);
        acc_b[0] = last_acc[1];
        issue(1, 0, 2'b10, BASE + 32'h10,   32'h0,        32'h00000055, 0,   1);
        acc_b[1] = last_acc[1];
        issue(1, 0, 2'b00, BASE + 32'h10,   32'h0,        32'h00000055, 0,   1);
        acc_b[2] = last_acc[1];
        check("b_accept_gap1", 32'(acc_b[1] - acc_b[0]), 32'd3);
        check("b_accept_gap2", 32'(acc_b[2] - acc_b[1]), 32'd3);

        drain();
        repeat (5) @(negedge clk);
        check("a_pending_rsp", 32'(qa.size()), 32'd0);
        check("b_pending_rsp", 32'(qb.size()), 32'd0);
        check("unexpected_rsp", 32'(unexpected), 32'd0);
        errors += unexpected;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
